// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: decode register file with two bypassed read ports, one writeback port and a RAW/WAW pending-write scoreboard
module regfile_scoreboard #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 5,
  parameter logic [31:0] RESET_BASE = 32'h100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dst,
  output logic              stall,
  output logic [ADDR_W:0]   pending_count
);
  localparam int NREGS = 2**ADDR_W;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d, wb_mask, set_mask, eff;
  logic [ADDR_W:0] count_q, count_d;
  logic wb_hit, accept, set_new, clr_old;
  assign wb_hit = wb_en && wb_addr != '0;
  assign wb_mask = wb_hit ? NREGS'(1) << wb_addr : '0;
  // a writeback landing this cycle already resolves its hazard
  assign eff = pend_q & ~wb_mask;
  assign stall = issue_en && (eff[rs_addr] || eff[rt_addr] || eff[issue_dst]);
  assign accept = issue_en && !stall && issue_dst != '0;
  assign set_mask = accept ? NREGS'(1) << issue_dst : '0;
  assign pend_d = (pend_q & ~wb_mask) | set_mask;
  assign set_new = accept && !pend_q[issue_dst];
  assign clr_old = wb_hit && pend_q[wb_addr] && !(accept && issue_dst == wb_addr);
  assign count_d = count_q + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr_old);
  assign pending_count = count_q;
  assign rs_data = rs_addr == '0 ? '0 : (wb_en && wb_addr == rs_addr) ? wb_data : regs_q[rs_addr];
  assign rt_data = rt_addr == '0 ? '0 : (wb_en && wb_addr == rt_addr) ? wb_data : regs_q[rt_addr];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        regs_q[r] <= r == 0 ? '0 : DATA_W'(RESET_BASE + r);
      else if (wb_hit && wb_addr == ADDR_W'(r))
        regs_q[r] <= wb_data;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and random stimulus against an array-based reference model, checked through an expectation queue
module tb_regfile_scoreboard;
  logic        clock = 0, reset = 1;
  logic [4:0]  rs_addr = 0, rt_addr = 0, wb_addr = 0, issue_dst = 0;
  logic [31:0] rs_data, rt_data, wb_data = 0;
  logic        wb_en = 0, issue_en = 0, stall;
  logic [5:0]  pending_count;

  regfile_scoreboard dut (
    .clock(clock), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .issue_en(issue_en), .issue_dst(issue_dst),
    .stall(stall), .pending_count(pending_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    logic [31:0] rs, rt;
    logic        st;
    logic [5:0]  cnt;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, n = 0;

  logic [31:0] mregs [32];
  bit          mpend [32];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = i == 0 ? 32'h0 : 32'h100 + 32'(i);
      mpend[i] = 0;
    end
  endfunction

  function automatic logic [31:0] m_read(int a);
    if (a == 0) return 0;
    if (wb_en && int'(wb_addr) == a) return wb_data;
    return mregs[a];
  endfunction

  function automatic bit m_busy(int a);
    return a != 0 && mpend[a] && !(wb_en && int'(wb_addr) == a);
  endfunction

  function automatic logic [5:0] m_count();
    int c = 0;
    foreach (mpend[i]) c += int'(mpend[i]);
    return 6'(c);
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.id  = n++;
    e.rs  = m_read(int'(rs_addr));
    e.rt  = m_read(int'(rt_addr));
    e.st  = issue_en && (m_busy(int'(rs_addr)) || m_busy(int'(rt_addr)) || m_busy(int'(issue_dst)));
    e.cnt = m_count();
    q.push_back(e);
  endfunction

  task automatic cycle(bit ie, int dst, int rs, int rt, bit we, int wa, logic [31:0] wd);
    bit accepted;
    @(negedge clock); #1;
    issue_en = ie; issue_dst = 5'(dst); rs_addr = 5'(rs); rt_addr = 5'(rt);
    wb_en = we; wb_addr = 5'(wa); wb_data = wd;
    push_exp();
    accepted = ie && !q[$].st;
    if (we && wa != 0) begin
      mregs[wa] = wd;
      mpend[wa] = 0;
    end
    if (accepted && dst != 0) mpend[dst] = 1;
  endtask

  task automatic reset_pulse(int rs, int rt);
    @(negedge clock); #1;
    reset = 1; issue_en = 0; wb_en = 0; rs_addr = 5'(rs); rt_addr = 5'(rt);
    model_reset();
    push_exp();
    #3 reset = 0;
  endtask

  task automatic chk(string name, int id, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s id=%0d actual=%h required=%h", name, id, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock); #3;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("rs_data", e.id, rs_data, e.rs);
        chk("rt_data", e.id, rt_data, e.rt);
        chk("stall", e.id, 32'(stall), 32'(e.st));
        chk("pending_count", e.id, 32'(pending_count), 32'(e.cnt));
      end
    end
  end

  initial begin : driver
    model_reset();
    repeat (2) @(negedge clock);
    reset = 0;
    cycle(0, 0, 0, 5, 0, 0, 0);
    cycle(0, 0, 7, 0, 1, 7, 32'hDEADBEEF);
    cycle(0, 0, 7, 7, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
    cycle(0, 0, 0, 7, 0, 0, 0);
    cycle(1, 3, 1, 2, 0, 0, 0);
    cycle(1, 0, 3, 1, 0, 0, 0);
    cycle(1, 0, 3, 1, 0, 0, 0);
    cycle(1, 0, 3, 1, 1, 3, 32'h55);
    cycle(0, 0, 3, 0, 0, 0, 0);
    cycle(1, 4, 1, 2, 0, 0, 0);
    cycle(1, 4, 1, 2, 0, 0, 0);
    cycle(1, 4, 1, 2, 1, 4, 32'h44);
    cycle(1, 4, 4, 0, 0, 0, 0);
    reset_pulse(4, 3);
    cycle(1, 1, 0, 0, 0, 0, 0);
    cycle(1, 2, 0, 0, 0, 0, 0);
    cycle(1, 9, 0, 0, 0, 0, 0);
    cycle(1, 10, 0, 0, 1, 2, 32'h22);
    cycle(0, 0, 2, 10, 1, 9, 32'h99);
    cycle(0, 0, 9, 1, 1, 5, 32'h5555);
    reset_pulse(9, 5);
    cycle(0, 0, 9, 5, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) reset_pulse(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      else cycle($urandom_range(0, 1) == 1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)), $urandom);
    end
    @(negedge clock); #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 entries left", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
